// File: rtl/id_stage_hz_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU-op encodings and
// the control bundle carried through the ID/EX register.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  // Unknown opcodes decode to an all-zero bundle so they behave as NOPs.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_RTYPE;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_BRANCH;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_hz_regfile_bypass.sv
// Two-read, one-write register file with r0 hardwired to zero and same-cycle
// write-through so a WB write is visible to the instruction reading it in ID.
module regfile_bypass #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_1,
  input  logic [4:0]        rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2
);

  logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;

  // Out-of-range and r0 addresses match no entry, so they read 0 and never write.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]                      addr,
    input logic [NUM_REGS-1:1][DATA_W-1:0] regs,
    input logic                            we,
    input logic [4:0]                      waddr,
    input logic [DATA_W-1:0]               wdata
  );
    logic [DATA_W-1:0] data;
    data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == 5'(i)) data = (we && waddr == addr) ? wdata : regs[i];
    end
    return data;
  endfunction

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_en && wr_addr == 5'(i)) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign rd_data_1 = read_port(rd_addr_1, regs_q, wr_en, wr_addr, wr_data);
  assign rd_data_2 = read_port(rd_addr_2, regs_q, wr_en, wr_addr, wr_data);

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage with hazard detection, early beq/bne resolution using EX/MEM
// forwarding, and the ID/EX pipeline register.
module id_stage_hz
  import id_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [31:0]       i_next_pc,
  input  logic [31:0]       i_instruction,
  input  logic              i_reg_write,
  input  logic [4:0]        i_write_register,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_mem_reg_write,
  input  logic              i_mem_mem_read,
  input  logic [4:0]        i_mem_write_register,
  input  logic [DATA_W-1:0] i_mem_alu_result,
  output logic              o_stall,
  output logic              o_branch_taken,
  output logic [31:0]       o_branch_target,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_read_data_1,
  output logic [DATA_W-1:0] o_read_data_2,
  output logic [DATA_W-1:0] o_sign_extended_imm,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_write_register,
  output logic [5:0]        o_function,
  output logic              o_alu_src,
  output logic [1:0]        o_alu_op,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_to_reg,
  output logic              o_branch
);

  logic [5:0]         opcode;
  logic [4:0]         rs, rt, rd;
  logic [15:0]        imm;
  logic signed [15:0] imm_s;
  ctrl_t              dec_ctrl;
  logic               is_branch, uses_rt;
  logic [DATA_W-1:0]  rf_data_1, rf_data_2, sext_imm;

  assign opcode    = i_instruction[31:26];
  assign rs        = i_instruction[25:21];
  assign rt        = i_instruction[20:16];
  assign rd        = i_instruction[15:11];
  assign imm       = i_instruction[15:0];
  assign imm_s     = imm;
  assign sext_imm  = DATA_W'(imm_s);
  assign dec_ctrl  = decode_ctrl(opcode);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_branch;

  regfile_bypass #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (i_reg_write),
    .wr_addr   (i_write_register),
    .wr_data   (i_write_data),
    .rd_addr_1 (rs),
    .rd_addr_2 (rt),
    .rd_data_1 (rf_data_1),
    .rd_data_2 (rf_data_2)
  );

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] read_data_1_q, read_data_1_d;
  logic [DATA_W-1:0] read_data_2_q, read_data_2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic [5:0]        funct_q, funct_d;

  logic              ex_hit_rs, ex_hit_rt, mem_hit, load_use, branch_stall, stall;
  logic              fwd_1, fwd_2, operands_eq, issue;
  logic [DATA_W-1:0] cmp_1, cmp_2;

  // The ID/EX destination is only a hazard when it names a real register.
  always_comb begin
    ex_hit_rs    = (wr_q != 5'd0) && (wr_q == rs);
    ex_hit_rt    = (wr_q != 5'd0) && (wr_q == rt);
    mem_hit      = (i_mem_write_register != 5'd0) &&
                   (i_mem_write_register == rs || i_mem_write_register == rt);
    load_use     = valid_q && ctrl_q.mem_read && (ex_hit_rs || (uses_rt && ex_hit_rt));
    branch_stall = BRANCH_IN_ID && is_branch &&
                   ((valid_q && ctrl_q.reg_write && (ex_hit_rs || ex_hit_rt)) ||
                    (i_mem_mem_read && mem_hit));
    stall        = !reset && i_valid && (load_use || branch_stall);
  end

  always_comb begin
    fwd_1       = i_mem_reg_write && !i_mem_mem_read &&
                  (i_mem_write_register != 5'd0) && (i_mem_write_register == rs);
    fwd_2       = i_mem_reg_write && !i_mem_mem_read &&
                  (i_mem_write_register != 5'd0) && (i_mem_write_register == rt);
    cmp_1       = fwd_1 ? i_mem_alu_result : rf_data_1;
    cmp_2       = fwd_2 ? i_mem_alu_result : rf_data_2;
    operands_eq = (cmp_1 == cmp_2);
  end

  assign o_stall         = stall;
  assign o_branch_taken  = BRANCH_IN_ID && !reset && i_valid && !stall &&
                           (((opcode == OP_BEQ) && operands_eq) ||
                            ((opcode == OP_BNE) && !operands_eq));
  assign o_branch_target = i_next_pc + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    issue         = i_valid && !stall;
    valid_d       = 1'b0;
    ctrl_d        = '0;
    read_data_1_d = '0;
    read_data_2_d = '0;
    imm_d         = '0;
    rs_d          = '0;
    rt_d          = '0;
    wr_d          = '0;
    funct_d       = '0;
    if (issue) begin
      valid_d       = 1'b1;
      ctrl_d        = dec_ctrl;
      read_data_1_d = rf_data_1;
      read_data_2_d = rf_data_2;
      imm_d         = sext_imm;
      rs_d          = rs;
      rt_d          = rt;
      wr_d          = (opcode == OP_RTYPE) ? rd : rt;
      funct_d       = i_instruction[5:0];
      // A branch already resolved here must not be acted on again in EX.
      if (BRANCH_IN_ID && is_branch) ctrl_d.branch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      ctrl_q        <= '0;
      read_data_1_q <= '0;
      read_data_2_q <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      wr_q          <= '0;
      funct_q       <= '0;
    end else begin
      valid_q       <= valid_d;
      ctrl_q        <= ctrl_d;
      read_data_1_q <= read_data_1_d;
      read_data_2_q <= read_data_2_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      wr_q          <= wr_d;
      funct_q       <= funct_d;
    end
  end

  assign o_valid             = valid_q;
  assign o_read_data_1       = read_data_1_q;
  assign o_read_data_2       = read_data_2_q;
  assign o_sign_extended_imm = imm_q;
  assign o_rs                = rs_q;
  assign o_rt                = rt_q;
  assign o_write_register    = wr_q;
  assign o_function          = funct_q;
  assign o_alu_src           = ctrl_q.alu_src;
  assign o_alu_op            = ctrl_q.alu_op;
  assign o_reg_write         = ctrl_q.reg_write;
  assign o_mem_read          = ctrl_q.mem_read;
  assign o_mem_write         = ctrl_q.mem_write;
  assign o_mem_to_reg        = ctrl_q.mem_to_reg;
  assign o_branch            = ctrl_q.branch;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: directed pipeline scenarios then random traffic, all
// checked against a behavioural decode/hazard model of the main instance.
module tb_id_stage_hz;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, i_valid, i_reg_write, i_mem_reg_write, i_mem_mem_read;
  logic [31:0] i_next_pc, i_instruction, i_write_data, i_mem_alu_result;
  logic [4:0]  i_write_register, i_mem_write_register;

  logic        m_stall, m_taken, m_valid, m_alu_src, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg, m_branch;
  logic [31:0] m_target, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_wr;
  logic [5:0]  m_funct;
  logic [1:0]  m_alu_op;

  logic        s_stall, s_taken, s_valid, s_alu_src, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_branch;
  logic [31:0] s_target, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_wr;
  logic [5:0]  s_funct;
  logic [1:0]  s_alu_op;

  logic        n_stall, n_taken, n_valid, n_alu_src, n_reg_write, n_mem_read, n_mem_write, n_mem_to_reg, n_branch;
  logic [31:0] n_target, n_rd1, n_rd2, n_imm;
  logic [4:0]  n_rs, n_rt, n_wr;
  logic [5:0]  n_funct;
  logic [1:0]  n_alu_op;

  id_stage_hz dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_next_pc(i_next_pc), .i_instruction(i_instruction),
    .i_reg_write(i_reg_write), .i_write_register(i_write_register), .i_write_data(i_write_data),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_mem_read(i_mem_mem_read),
    .i_mem_write_register(i_mem_write_register), .i_mem_alu_result(i_mem_alu_result),
    .o_stall(m_stall), .o_branch_taken(m_taken), .o_branch_target(m_target), .o_valid(m_valid),
    .o_read_data_1(m_rd1), .o_read_data_2(m_rd2), .o_sign_extended_imm(m_imm),
    .o_rs(m_rs), .o_rt(m_rt), .o_write_register(m_wr), .o_function(m_funct),
    .o_alu_src(m_alu_src), .o_alu_op(m_alu_op), .o_reg_write(m_reg_write), .o_mem_read(m_mem_read),
    .o_mem_write(m_mem_write), .o_mem_to_reg(m_mem_to_reg), .o_branch(m_branch)
  );

  id_stage_hz #(.NUM_REGS(8)) dut_small (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_next_pc(i_next_pc), .i_instruction(i_instruction),
    .i_reg_write(i_reg_write), .i_write_register(i_write_register), .i_write_data(i_write_data),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_mem_read(i_mem_mem_read),
    .i_mem_write_register(i_mem_write_register), .i_mem_alu_result(i_mem_alu_result),
    .o_stall(s_stall), .o_branch_taken(s_taken), .o_branch_target(s_target), .o_valid(s_valid),
    .o_read_data_1(s_rd1), .o_read_data_2(s_rd2), .o_sign_extended_imm(s_imm),
    .o_rs(s_rs), .o_rt(s_rt), .o_write_register(s_wr), .o_function(s_funct),
    .o_alu_src(s_alu_src), .o_alu_op(s_alu_op), .o_reg_write(s_reg_write), .o_mem_read(s_mem_read),
    .o_mem_write(s_mem_write), .o_mem_to_reg(s_mem_to_reg), .o_branch(s_branch)
  );

  id_stage_hz #(.BRANCH_IN_ID(1'b0)) dut_nobr (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_next_pc(i_next_pc), .i_instruction(i_instruction),
    .i_reg_write(i_reg_write), .i_write_register(i_write_register), .i_write_data(i_write_data),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_mem_read(i_mem_mem_read),
    .i_mem_write_register(i_mem_write_register), .i_mem_alu_result(i_mem_alu_result),
    .o_stall(n_stall), .o_branch_taken(n_taken), .o_branch_target(n_target), .o_valid(n_valid),
    .o_read_data_1(n_rd1), .o_read_data_2(n_rd2), .o_sign_extended_imm(n_imm),
    .o_rs(n_rs), .o_rt(n_rt), .o_write_register(n_wr), .o_function(n_funct),
    .o_alu_src(n_alu_src), .o_alu_op(n_alu_op), .o_reg_write(n_reg_write), .o_mem_read(n_mem_read),
    .o_mem_write(n_mem_write), .o_mem_to_reg(n_mem_to_reg), .o_branch(n_branch)
  );

  typedef struct packed {
    bit        valid;
    bit        alu_src;
    bit [1:0]  alu_op;
    bit        reg_write;
    bit        mem_read;
    bit        mem_write;
    bit        mem_to_reg;
    bit        branch;
    bit [31:0] rd1;
    bit [31:0] rd2;
    bit [31:0] imm;
    bit [4:0]  rs;
    bit [4:0]  rt;
    bit [4:0]  wr;
    bit [5:0]  funct;
  } idex_t;

  idex_t     exp_q, exp_d;
  bit [31:0] mregs [32];
  int        n_cmp = 0;
  int        n_bad = 0;
  logic      obs_stall, obs_taken, obs_n_stall, obs_n_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural register value as seen by ID this cycle, including the WB write.
  function automatic bit [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_reg_write && i_write_register == a) return i_write_data;
    return mregs[a];
  endfunction

  task automatic checkOutput();
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    bit          is_br, uses_rt, lu, bs, fa, fb, exp_stall, exp_taken;
    bit [31:0]   a, b, exp_target;
    int          simm;
    check("reg_valid", 32'(m_valid), 32'(exp_q.valid));
    check("reg_alu_src", 32'(m_alu_src), 32'(exp_q.alu_src));
    check("reg_alu_op", 32'(m_alu_op), 32'(exp_q.alu_op));
    check("reg_reg_write", 32'(m_reg_write), 32'(exp_q.reg_write));
    check("reg_mem_read", 32'(m_mem_read), 32'(exp_q.mem_read));
    check("reg_mem_write", 32'(m_mem_write), 32'(exp_q.mem_write));
    check("reg_mem_to_reg", 32'(m_mem_to_reg), 32'(exp_q.mem_to_reg));
    check("reg_branch", 32'(m_branch), 32'(exp_q.branch));
    if (exp_q.valid) begin
      check("reg_rd1", m_rd1, exp_q.rd1);
      check("reg_rd2", m_rd2, exp_q.rd2);
      check("reg_imm", m_imm, exp_q.imm);
      check("reg_rs", 32'(m_rs), 32'(exp_q.rs));
      check("reg_rt", 32'(m_rt), 32'(exp_q.rt));
      check("reg_wr", 32'(m_wr), 32'(exp_q.wr));
      check("reg_funct", 32'(m_funct), 32'(exp_q.funct));
    end
    op      = i_instruction[31:26];
    rs      = i_instruction[25:21];
    rt      = i_instruction[20:16];
    is_br   = (op == 6'd4) || (op == 6'd5);
    uses_rt = (op == 6'd0) || (op == 6'd43) || is_br;
    lu = exp_q.valid && exp_q.mem_read && exp_q.wr != 0 && (exp_q.wr == rs || (uses_rt && exp_q.wr == rt));
    bs = is_br && ((exp_q.valid && exp_q.reg_write && exp_q.wr != 0 && (exp_q.wr == rs || exp_q.wr == rt)) ||
                   (i_mem_mem_read && i_mem_write_register != 0 &&
                    (i_mem_write_register == rs || i_mem_write_register == rt)));
    exp_stall = !reset && i_valid && (lu || bs);
    fa = i_mem_reg_write && !i_mem_mem_read && i_mem_write_register != 0 && i_mem_write_register == rs;
    fb = i_mem_reg_write && !i_mem_mem_read && i_mem_write_register != 0 && i_mem_write_register == rt;
    a  = fa ? i_mem_alu_result : mread(rs);
    b  = fb ? i_mem_alu_result : mread(rt);
    exp_taken  = !reset && i_valid && !exp_stall && ((op == 6'd4 && a == b) || (op == 6'd5 && a != b));
    simm       = int'($signed(i_instruction[15:0]));
    exp_target = i_next_pc + 32'(simm * 4);
    obs_stall   = m_stall;
    obs_taken   = m_taken;
    obs_n_stall = n_stall;
    obs_n_taken = n_taken;
    check("stall", 32'(m_stall), 32'(exp_stall));
    check("branch_taken", 32'(m_taken), 32'(exp_taken));
    if (i_valid && !reset) check("branch_target", m_target, exp_target);
    exp_d = '0;
    if (i_valid && !exp_stall) begin
      exp_d.valid = 1'b1;
      case (op)
        6'd0:  begin exp_d.reg_write = 1; exp_d.alu_op = 2'd2; end
        6'd35: begin exp_d.alu_src = 1; exp_d.mem_read = 1; exp_d.mem_to_reg = 1; exp_d.reg_write = 1; end
        6'd43: begin exp_d.alu_src = 1; exp_d.mem_write = 1; end
        6'd8:  begin exp_d.alu_src = 1; exp_d.reg_write = 1; end
        6'd4, 6'd5: exp_d.alu_op = 2'd1;
        default: ;
      endcase
      exp_d.rd1   = mread(rs);
      exp_d.rd2   = mread(rt);
      exp_d.imm   = 32'(simm);
      exp_d.rs    = rs;
      exp_d.rt    = rt;
      exp_d.wr    = (op == 6'd0) ? i_instruction[15:11] : rt;
      exp_d.funct = i_instruction[5:0];
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] npc,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic mrw, input logic mmr, input logic [4:0] mwa, input logic [31:0] malu);
    i_valid = v; i_instruction = instr; i_next_pc = npc;
    i_reg_write = we; i_write_register = wa; i_write_data = wd;
    i_mem_reg_write = mrw; i_mem_mem_read = mmr; i_mem_write_register = mwa; i_mem_alu_result = malu;
    #1;
    checkOutput();
    @(posedge clk);
    if (reset) begin
      exp_q = '0;
      foreach (mregs[k]) mregs[k] = 32'd0;
    end else begin
      exp_q = exp_d;
      if (we && wa != 5'd0) mregs[wa] = wd;
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [31:0] instr, input logic [31:0] npc);
    applyStimulus(1'b1, instr, npc, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 0; i_instruction = 0; i_next_pc = 0; i_reg_write = 0; i_write_register = 0; i_write_data = 0;
    i_mem_reg_write = 0; i_mem_mem_read = 0; i_mem_write_register = 0; i_mem_alu_result = 0;
    exp_q = '0;
    foreach (mregs[k]) mregs[k] = 32'd0;
    @(posedge clk);
    @(negedge clk);

    $display("[TB] reset state");
    step(enc_r(5'd2, 5'd1, 5'd3, 6'h20), 32'h4);
    check("reset_valid", 32'(m_valid), 32'd0);
    reset = 1'b0;

    $display("[TB] addi decode");
    step(enc_i(6'd8, 5'd0, 5'd1, 16'd5), 32'h8);
    check("addi_valid", 32'(m_valid), 32'd1);
    check("addi_alu_src", 32'(m_alu_src), 32'd1);
    check("addi_reg_write", 32'(m_reg_write), 32'd1);
    check("addi_imm", m_imm, 32'd5);
    check("addi_wr", 32'(m_wr), 32'd1);

    $display("[TB] load-use");
    step(enc_i(6'd35, 5'd1, 5'd2, 16'd0), 32'hC);
    step(enc_r(5'd2, 5'd1, 5'd3, 6'h20), 32'h10);
    check("lu_stall", 32'(obs_stall), 32'd1);
    check("lu_bubble", 32'(m_valid), 32'd0);
    step(enc_r(5'd2, 5'd1, 5'd3, 6'h20), 32'h10);
    check("lu_release", 32'(obs_stall), 32'd0);
    check("lu_issue_wr", 32'(m_wr), 32'd3);

    $display("[TB] beq to self");
    step(enc_i(6'd4, 5'd4, 5'd4, 16'hFFFF), 32'h104);
    check("beq_taken", 32'(obs_taken), 32'd1);
    check("beq_no_regwrite", 32'(m_reg_write), 32'd0);
    check("beq_no_branch", 32'(m_branch), 32'd0);

    $display("[TB] bne with forwarding");
    step(enc_i(6'd8, 5'd0, 5'd5, 16'd7), 32'h1FC);
    step(enc_i(6'd5, 5'd5, 5'd0, 16'd3), 32'h200);
    check("bne_ex_stall", 32'(obs_stall), 32'd1);
    applyStimulus(1'b1, enc_i(6'd5, 5'd5, 5'd0, 16'd3), 32'h200, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 32'd7);
    check("bne_fwd_taken", 32'(obs_taken), 32'd1);

    $display("[TB] branch behind load");
    step(enc_i(6'd35, 5'd1, 5'd2, 16'd0), 32'h300);
    step(enc_i(6'd4, 5'd2, 5'd1, 16'd2), 32'h304);
    check("ldbr_stall_ex", 32'(obs_stall), 32'd1);
    applyStimulus(1'b1, enc_i(6'd4, 5'd2, 5'd1, 16'd2), 32'h304, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd2, 32'h40);
    check("ldbr_stall_mem", 32'(obs_stall), 32'd1);
    applyStimulus(1'b1, enc_i(6'd4, 5'd2, 5'd1, 16'd2), 32'h304, 1'b1, 5'd2, 32'd5, 1'b0, 1'b0, 5'd0, 32'd0);
    check("ldbr_release", 32'(obs_stall), 32'd0);

    $display("[TB] WB bypass and r0");
    applyStimulus(1'b1, enc_r(5'd6, 5'd0, 5'd7, 6'h20), 32'h400, 1'b1, 5'd6, 32'hDEAD, 1'b0, 1'b0, 5'd0, 32'd0);
    check("bypass_rd1", m_rd1, 32'hDEAD);
    applyStimulus(1'b1, enc_r(5'd0, 5'd0, 5'd8, 6'h20), 32'h404, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 5'd0, 32'd0);
    check("r0_rd1", m_rd1, 32'd0);

    $display("[TB] NUM_REGS=8 instance");
    applyStimulus(1'b1, enc_r(5'd12, 5'd12, 5'd3, 6'h20), 32'h500, 1'b1, 5'd12, 32'h1234, 1'b0, 1'b0, 5'd0, 32'd0);
    check("small_r12_bypass", s_rd1, 32'd0);
    step(enc_r(5'd12, 5'd0, 5'd3, 6'h20), 32'h504);
    check("small_r12_read", s_rd1, 32'd0);
    applyStimulus(1'b1, enc_r(5'd7, 5'd0, 5'd3, 6'h20), 32'h508, 1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 5'd0, 32'd0);
    check("small_r7_read", s_rd1, 32'h55);

    $display("[TB] branch resolved in EX instance");
    step(enc_i(6'd8, 5'd0, 5'd9, 16'd1), 32'h600);
    step(enc_i(6'd4, 5'd9, 5'd0, 16'd1), 32'h604);
    check("nobr_stall", 32'(obs_n_stall), 32'd0);
    check("nobr_taken", 32'(obs_n_taken), 32'd0);
    check("nobr_branch", 32'(n_branch), 32'd1);
    check("nobr_valid", 32'(n_valid), 32'd1);

    $display("[TB] reset during stall");
    step(enc_i(6'd35, 5'd1, 5'd2, 16'd0), 32'h700);
    step(enc_r(5'd2, 5'd1, 5'd3, 6'h20), 32'h704);
    reset = 1'b1;
    step(enc_r(5'd2, 5'd1, 5'd3, 6'h20), 32'h704);
    check("rst_no_stall", 32'(obs_stall), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_mem_read", 32'(m_mem_read), 32'd0);
    reset = 1'b0;
    step(enc_r(5'd2, 5'd1, 5'd3, 6'h20), 32'h704);
    check("post_rst_stall", 32'(obs_stall), 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] instr;
      case ($urandom_range(0, 6))
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd8;
        4: op = 6'd4;
        5: op = 6'd5;
        default: op = 6'($urandom());
      endcase
      instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom())};
      applyStimulus(($urandom_range(0, 7) != 0), instr, {$urandom(), 2'b00} & 32'hFFFF_FFFC,
                    1'($urandom()), 5'($urandom_range(0, 7)), $urandom_range(0, 3),
                    1'($urandom()), 1'($urandom()), 5'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
